// File: rtl/test_status_mon.sv
// ---------------------------------------------------------------------------
// test_status_mon
//   End-of-test monitor sitting on the core's decode/execute boundary.
//   While the test runs it counts cycles, issued instructions and issues at
//   the write_tohost PC. When that PC has been issued HIT_COUNT times the
//   counters freeze and the result is produced either from x3 (chk_en=0) or
//   by reading a signature region word by word over a single-outstanding
//   read port and comparing every word against a combinational reference ROM.
//
// Ports
//   clk, cpurst_n          core clock, asynchronous active-low reset
//   inst_valid, dec_pc     decode-to-execute valid strobe and decode PC
//   x3                     architectural x3 (non-signature result)
//   chk_en                 1 = signature compare, 0 = pass iff x3 == 1
//   sig_base, sig_len      signature byte address / word count (0..256)
//   mem_req, mem_addr      read request and byte address (held until grant)
//   mem_gnt                request accepted this cycle
//   mem_rvalid, mem_rdata  read data return
//   ref_idx, ref_data      reference ROM index / expected word (same cycle)
//   cycle_cnt, instr_cnt   frozen cycle and instruction counters
//   busy, done, pass       status flags (done/pass sticky until reset)
//   fail_idx, mism_cnt     first mismatching word (9'h1FF if none) / count
// ---------------------------------------------------------------------------
module test_status_mon #(
  parameter logic [31:0] TOHOST_PC = 32'h8000_0086,
  parameter int unsigned HIT_COUNT = 8
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        inst_valid,
  input  logic [31:0] dec_pc,
  input  logic [31:0] x3,
  input  logic        chk_en,
  input  logic [31:0] sig_base,
  input  logic [8:0]  sig_len,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  ref_idx,
  input  logic [31:0] ref_data,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  fail_idx,
  output logic [8:0]  mism_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] HIT_TGT  = 8'(HIT_COUNT);
  localparam logic [8:0] NO_FAIL  = 9'h1FF;

  logic [1:0]  state_q,     state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [7:0]  hit_cnt_q,   hit_cnt_d;
  logic [8:0]  idx_q,       idx_d;
  logic        mem_req_q,   mem_req_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [7:0]  ref_idx_q,   ref_idx_d;
  logic        ok_q,        ok_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        pass_q,      pass_d;
  logic [8:0]  fail_idx_q,  fail_idx_d;
  logic [8:0]  mism_cnt_q,  mism_cnt_d;

  logic        hit_s;
  logic [8:0]  next_idx_s;
  logic        word_mis_s;

  // Byte address of signature word idx (idx is 9 bit so 256 words never alias).
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [8:0] idx);
    return base + {21'd0, idx, 2'b00};
  endfunction

  // Next-state and datapath logic for the run/request/wait/done sequence.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    idx_d       = idx_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ref_idx_d   = ref_idx_q;
    ok_d        = ok_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_idx_d  = fail_idx_q;
    mism_cnt_d  = mism_cnt_q;

    hit_s      = inst_valid && (dec_pc == TOHOST_PC);
    next_idx_s = idx_q + 9'd1;
    word_mis_s = (mem_rdata != ref_data);

    case (state_q)
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (inst_valid) begin
          instr_cnt_d = instr_cnt_q + 32'd1;
        end else begin
          instr_cnt_d = instr_cnt_q;
        end
        if (hit_s) begin
          hit_cnt_d = hit_cnt_q + 8'd1;
          // Detect edge: counters above take their last step, then freeze.
          if ((hit_cnt_q + 8'd1) == HIT_TGT) begin
            if (!chk_en) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = (x3 == 32'd1);
            end else if (sig_len == 9'd0) begin
              // Empty signature: nothing to compare, trivially passes.
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d    = ST_REQ;
              busy_d     = 1'b1;
              ok_d       = 1'b1;
              idx_d      = 9'd0;
              mem_req_d  = 1'b1;
              mem_addr_d = sig_base;
              ref_idx_d  = 8'd0;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          hit_cnt_d = hit_cnt_q;
        end
      end

      ST_REQ: begin
        // Request stays stable until accepted; any rvalid here is ignored.
        if (mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else begin
          state_d   = ST_REQ;
        end
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          if (word_mis_s) begin
            ok_d       = 1'b0;
            mism_cnt_d = mism_cnt_q + 9'd1;
            if (fail_idx_q == NO_FAIL) begin
              fail_idx_d = idx_q;
            end else begin
              fail_idx_d = fail_idx_q;
            end
          end else begin
            ok_d = ok_q;
          end
          idx_d = next_idx_s;
          if (next_idx_s == sig_len) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = ok_q && !word_mis_s;
          end else begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr(sig_base, next_idx_s);
            ref_idx_d  = next_idx_s[7:0];
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q     <= ST_RUN;
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
      hit_cnt_q   <= 8'd0;
      idx_q       <= 9'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      ref_idx_q   <= 8'd0;
      ok_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= NO_FAIL;
      mism_cnt_q  <= 9'd0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      idx_q       <= idx_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ref_idx_q   <= ref_idx_d;
      ok_q        <= ok_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_idx_q  <= fail_idx_d;
      mism_cnt_q  <= mism_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ref_idx   = ref_idx_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_idx_q;
  assign mism_cnt  = mism_cnt_q;

endmodule

// File: tb/tb_test_status_mon.sv
// ---------------------------------------------------------------------------
// tb_test_status_mon
//   Directed bench for test_status_mon. A behavioural model tracks counters,
//   detect and grant count; a memory responder serves reads from a ROM image
//   with optional corruption, grant stalls and stray rvalid pulses. One
//   negedge process compares DUT outputs with the model every cycle, and the
//   directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_test_status_mon;

  localparam logic [31:0] TOHOST = 32'h8000_0086;
  localparam int          HITS   = 8;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] dec_pc = 32'd0;
  logic [31:0] x3 = 32'd0;
  logic        chk_en = 1'b0;
  logic [31:0] sig_base = 32'h9000_0000;
  logic [8:0]  sig_len = 9'd4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [7:0]  ref_idx;
  logic [31:0] ref_data;
  logic [31:0] cycle_cnt, instr_cnt;
  logic        busy, done, pass;
  logic [8:0]  fail_idx, mism_cnt;

  always #5 clk = ~clk;

  test_status_mon dut (
    .clk(clk), .cpurst_n(cpurst_n), .inst_valid(inst_valid), .dec_pc(dec_pc),
    .x3(x3), .chk_en(chk_en), .sig_base(sig_base), .sig_len(sig_len),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ref_idx(ref_idx),
    .ref_data(ref_data), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .busy(busy), .done(done), .pass(pass), .fail_idx(fail_idx),
    .mism_cnt(mism_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ROM and memory image (ROM word, optionally corrupted).
  logic corrupt [0:255];

  function automatic logic [31:0] rom_word(input logic [7:0] i);
    return 32'hC0DE_0000 ^ {i, ~i, i, 8'h5A};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] off;
    logic [7:0]  k;
    off = addr - sig_base;
    k   = off[9:2];
    return corrupt[k] ? (rom_word(k) ^ 32'h0000_0100) : rom_word(k);
  endfunction

  assign ref_data = rom_word(ref_idx);

  // Expected signature result derived from the corruption map.
  logic       exp_pass;
  logic [8:0] exp_fail, exp_mism;

  task automatic compute_expect();
    exp_pass = 1'b1;
    exp_fail = 9'h1FF;
    exp_mism = 9'd0;
    for (int k = 0; k < int'(sig_len); k++) begin
      if (corrupt[k]) begin
        exp_pass = 1'b0;
        exp_mism = exp_mism + 9'd1;
        if (exp_fail == 9'h1FF) exp_fail = 9'(k);
      end
    end
  endtask

  // Behavioural model: counts until the HITS-th tohost issue, then freezes.
  logic [31:0] m_cyc, m_ins;
  int          m_hits, m_grants;
  logic        m_det, m_x3ok;

  always @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      m_cyc <= 32'd0; m_ins <= 32'd0; m_hits <= 0; m_grants <= 0;
      m_det <= 1'b0;  m_x3ok <= 1'b0;
    end else begin
      if (!m_det) begin
        m_cyc <= m_cyc + 32'd1;
        if (inst_valid) m_ins <= m_ins + 32'd1;
        if (inst_valid && dec_pc == TOHOST) begin
          m_hits <= m_hits + 1;
          if (m_hits + 1 == HITS) begin
            m_det  <= 1'b1;
            m_x3ok <= (x3 == 32'd1);
          end
        end
      end
      if (mem_req && mem_gnt) m_grants <= m_grants + 1;
    end
  end

  // Memory responder: 1-cycle read latency, optional stalls and stray rvalid.
  logic        g_seen = 1'b0;
  logic [31:0] g_addr = 32'd0;
  logic        rand_gnt = 1'b0;
  logic        spur_en = 1'b0;
  logic        armed = 1'b0;
  int          stall_left = 0;

  always @(negedge clk) begin
    g_seen <= mem_req && mem_gnt && cpurst_n;
    g_addr <= mem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (g_seen) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(g_addr);
    end else if (spur_en && ($urandom_range(0, 1) == 1)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
    end
    if (!rand_gnt) begin
      mem_gnt = 1'b1;
    end else if (mem_req) begin
      if (!armed) begin
        stall_left = $urandom_range(0, 3);
        armed      = 1'b1;
      end
      if (stall_left > 0) begin
        mem_gnt    = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        mem_gnt = 1'b1;
        armed   = 1'b0;
      end
    end else begin
      mem_gnt = 1'b0;
      armed   = 1'b0;
    end
  end

  // Per-cycle compare process against the model.
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [7:0]  last_ref = 8'd0;
  logic [31:0] gaddr_q [$];

  always @(negedge clk) begin
    if (!cpurst_n) begin
      chk("rst_cycle", cycle_cnt, 32'd0);
      chk("rst_instr", instr_cnt, 32'd0);
      chk("rst_flags", 32'({mem_req, busy, done, pass}), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_ref_idx", 32'(ref_idx), 32'd0);
      chk("rst_fail_idx", 32'(fail_idx), 32'h1FF);
      chk("rst_mism", 32'(mism_cnt), 32'd0);
      prev_req <= 1'b0;
    end else begin
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("instr_cnt", instr_cnt, m_ins);
      if (!m_det) begin
        chk("pre_detect_flags", 32'({busy, done, mem_req}), 32'd0);
        chk("pre_detect_fail_idx", 32'(fail_idx), 32'h1FF);
        chk("pre_detect_mism", 32'(mism_cnt), 32'd0);
      end
      if (mem_req) begin
        chk("req_addr", mem_addr, sig_base + 32'(m_grants * 4));
        chk("req_ref_idx", 32'(ref_idx), 32'(m_grants % 256));
        chk("req_busy", 32'(busy), 32'd1);
        last_ref <= ref_idx;
        if (mem_gnt) gaddr_q.push_back(mem_addr);
      end
      if (prev_req && !prev_gnt) begin
        chk("req_held", 32'(mem_req), 32'd1);
        chk("addr_held", mem_addr, prev_addr);
      end
      if (done) begin
        chk("done_pass", 32'(pass), 32'(chk_en ? exp_pass : m_x3ok));
        chk("done_fail_idx", 32'(fail_idx), chk_en ? 32'(exp_fail) : 32'h1FF);
        chk("done_mism", 32'(mism_cnt), chk_en ? 32'(exp_mism) : 32'd0);
        chk("done_idle", 32'({busy, mem_req}), 32'd0);
      end
      prev_req  <= mem_req;
      prev_gnt  <= mem_gnt;
      prev_addr <= mem_addr;
    end
  end

  // Stimulus helpers.
  task automatic step(input logic v, input logic [31:0] pc);
    inst_valid = v;
    dec_pc     = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpurst_n   = 1'b0;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    gaddr_q.delete();
    cpurst_n = 1'b1;
  endtask

  task automatic issue_hits(input int n);
    for (int i = 0; i < n; i++) step(1'b1, TOHOST);
    inst_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic clear_corrupt();
    for (int k = 0; k < 256; k++) corrupt[k] = 1'b0;
  endtask

  initial begin
    int c;
    clear_corrupt();

    // Non-check, x3=1, interleaved non-valid cycles at the tohost PC.
    chk_en = 1'b0; x3 = 32'd1; compute_expect();
    do_reset();
    step(1'b1, 32'h8000_0000);
    step(1'b1, 32'h8000_0004);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, TOHOST);
      if (i == 1 || i == 3 || i == 5) step(1'b0, TOHOST);
    end
    chk("t1_done_before_8th", 32'(done), 32'd0);
    step(1'b1, TOHOST);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_cycle", cycle_cnt, 32'd13);
    chk("t1_instr", instr_cnt, 32'd10);
    for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? TOHOST : 32'h8000_0010);
    chk("t1_cycle_frozen", cycle_cnt, 32'd13);
    chk("t1_instr_frozen", instr_cnt, 32'd10);
    chk("t1_sticky", 32'({done, pass}), 32'd3);

    // Non-check, x3=5 fails; later issues and x3 changes have no effect.
    x3 = 32'd5;
    do_reset();
    issue_hits(HITS);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_cycle", cycle_cnt, 32'd8);
    x3 = 32'd1;
    for (int i = 0; i < 4; i++) step(1'b1, TOHOST);
    chk("t2_pass_sticky", 32'(pass), 32'd0);
    chk("t2_instr_frozen", instr_cnt, 32'd8);

    // Check mode, 4 clean words, grant tied high.
    chk_en = 1'b1; sig_base = 32'h9000_0000; sig_len = 9'd4;
    clear_corrupt(); compute_expect();
    do_reset();
    issue_hits(HITS);
    chk("t3_req_after_detect", 32'({mem_req, done}), 32'd2);
    wait_done(50, c);
    chk("t3_done_latency", 32'(c), 32'd8);
    chk("t3_nreq", 32'(gaddr_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < gaddr_q.size(); k++)
      chk("t3_addr", gaddr_q[k], 32'h9000_0000 + 32'(k * 4));
    chk("t3_result", 32'({pass, fail_idx, mism_cnt}), {13'd0, 1'b1, 9'h1FF, 9'd0});

    // Check mode, words 1 and 3 corrupted, random grant stalls, stray rvalid.
    corrupt[1] = 1'b1; corrupt[3] = 1'b1; compute_expect();
    rand_gnt = 1'b1; spur_en = 1'b1;
    do_reset();
    issue_hits(HITS);
    wait_done(200, c);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_fail_idx", 32'(fail_idx), 32'd1);
    chk("t4_mism", 32'(mism_cnt), 32'd2);
    chk("t4_nreq", 32'(gaddr_q.size()), 32'd4);
    rand_gnt = 1'b0; spur_en = 1'b0;

    // sig_len=0: immediate pass, no request.
    sig_len = 9'd0; clear_corrupt(); compute_expect();
    do_reset();
    issue_hits(HITS);
    chk("t5a_done_pass", 32'({done, pass, mem_req}), 32'd6);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0);
    chk("t5a_no_req", 32'(gaddr_q.size()), 32'd0);

    // sig_len=256: full region, no index aliasing.
    sig_len = 9'd256; compute_expect();
    do_reset();
    issue_hits(HITS);
    wait_done(600, c);
    chk("t5b_latency", 32'(c), 32'd512);
    chk("t5b_nreq", 32'(gaddr_q.size()), 32'd256);
    if (gaddr_q.size() == 256) chk("t5b_last_addr", gaddr_q[255], 32'h9000_03FC);
    chk("t5b_last_ref_idx", 32'(last_ref), 32'd255);
    chk("t5b_result", 32'({pass, fail_idx, mism_cnt}), {13'd0, 1'b1, 9'h1FF, 9'd0});

    // Reset while waiting for read data, then a fresh run.
    sig_len = 9'd4; corrupt[0] = 1'b1; compute_expect();
    do_reset();
    issue_hits(HITS);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(mem_req && mem_gnt) && c < 20);
    chk("t6_grant_seen", 32'(mem_req && mem_gnt), 32'd1);
    @(posedge clk); #1;
    chk("t6_in_wait", 32'({busy, mem_req}), 32'd2);
    cpurst_n = 1'b0;
    spur_en  = 1'b1;
    #1;
    chk("t6_async_reset", 32'({busy, done, mem_req, pass}), 32'd0);
    chk("t6_reset_fail_idx", 32'(fail_idx), 32'h1FF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_held_reset", 32'({mism_cnt, done}), 32'd0);
    corrupt[0] = 1'b0; corrupt[2] = 1'b1; compute_expect();
    gaddr_q.delete();
    cpurst_n = 1'b1;
    issue_hits(HITS);
    chk("t6_cycle", cycle_cnt, 32'd8);
    wait_done(50, c);
    chk("t6_pass", 32'(pass), 32'd0);
    chk("t6_fail_idx", 32'(fail_idx), 32'd2);
    chk("t6_mism", 32'(mism_cnt), 32'd1);
    spur_en = 1'b0;

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
